// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM arbiter/controller: FSM states, half
// selectors, the latched request record and per-half lane/data selection.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    localparam int SRAM_AW_DEF = 20;
    localparam int REQ_AW      = SRAM_AW_DEF - 1;

    typedef struct packed {
        logic              we;
        logic [REQ_AW-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        be;
    } req_t;

    // A write half with no enabled byte is skipped; reads always need both halves.
    function automatic logic need_half(input logic we, input logic [3:0] be, input logic h);
        return !we || (h ? (|be[3:2]) : (|be[1:0]));
    endfunction

    // Returns {ub_n, lb_n} for the selected half.
    function automatic logic [1:0] half_lanes(input logic we, input logic [3:0] be, input logic h);
        if (!we)
            return 2'b00;
        return h ? ~be[3:2] : ~be[1:0];
    endfunction

    function automatic logic [15:0] half_data(input logic [31:0] w, input logic h);
        return h ? w[31:16] : w[15:0];
    endfunction

endpackage

// File: rtl/sram_arbiter_ctrl_rr.sv
// Two-way round-robin arbiter: the pointer names the favoured port and flips
// away from whichever port was granted when advance is pulsed.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (ptr == 1'b0) begin
            if (req[0])      grant = 2'b01;
            else if (req[1]) grant = 2'b10;
        end else begin
            if (req[1])      grant = 2'b10;
            else if (req[0]) grant = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= 1'b0;
        else if (advance)
            ptr <= grant[0];
    end

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// Dual-port 32-bit front end for a 16-bit asynchronous SRAM: arbitrates two
// requesters and sequences each word as two registered SETUP/STROBE/HOLD halves.
module sram_arbiter_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int SRAM_AW     = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [1:0][SRAM_AW-2:0] req_addr,
    input  logic [1:0][31:0]        req_wdata,
    input  logic [1:0][3:0]         req_be,
    output logic [1:0]              rsp_valid,
    output logic [31:0]             rsp_rdata,
    inout  wire  [15:0]             sram_dq,
    output logic [SRAM_AW-1:0]      sram_addr,
    output logic                    sram_ce_n,
    output logic                    sram_oe_n,
    output logic                    sram_we_n,
    output logic                    sram_lb_n,
    output logic                    sram_ub_n
);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t        state;
    logic          half;
    logic [CW-1:0] cnt;
    logic [1:0]    port;
    req_t          cur, nreq, src;
    logic [15:0]   rbuf_lo, rbuf_hi;
    logic          dq_oe;
    logic [15:0]   dq_out;

    logic [1:0] accept, grant, arb_req;
    logic       take, go_setup, setup_half, last_strobe;

    assign accept  = req_valid & req_ready;
    assign take    = (state == IDLE) && (|accept);
    // On the accept cycle the arbiter sees only the accepted port so the pointer flips away from it.
    assign arb_req = take ? accept : req_valid;
    assign last_strobe = (state == STROBE) && (cnt == CW'(WAIT_CYCLES - 1));
    assign sram_dq = dq_oe ? dq_out : 16'bz;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (arb_req),
        .advance (take),
        .grant   (grant)
    );

    always_comb begin
        nreq.we    = req_we[accept[1]];
        nreq.addr  = REQ_AW'(req_addr[accept[1]]);
        nreq.wdata = req_wdata[accept[1]];
        nreq.be    = req_be[accept[1]];
    end

    always_comb begin
        go_setup   = 1'b0;
        setup_half = HALF_LO;
        src        = cur;
        if (take) begin
            src = nreq;
            if (need_half(nreq.we, nreq.be, HALF_LO)) begin
                go_setup = 1'b1;
            end else if (need_half(nreq.we, nreq.be, HALF_HI)) begin
                go_setup   = 1'b1;
                setup_half = HALF_HI;
            end
        end else if (state == HOLD && half == HALF_LO && need_half(cur.we, cur.be, HALF_HI)) begin
            go_setup   = 1'b1;
            setup_half = HALF_HI;
        end
    end

    // Datapath registers: request latch, write-data pins and read capture.
    always_ff @(posedge clk) begin
        if (take)
            cur <= nreq;
        if (go_setup)
            dq_out <= half_data(src.wdata, setup_half);
        if (last_strobe && !cur.we) begin
            if (half == HALF_HI) rbuf_hi <= sram_dq;
            else                 rbuf_lo <= sram_dq;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            half      <= HALF_LO;
            cnt       <= '0;
            port      <= 2'b00;
            req_ready <= 2'b00;
            rsp_valid <= 2'b00;
            rsp_rdata <= 32'h0;
            dq_oe     <= 1'b0;
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_lb_n <= 1'b1;
            sram_ub_n <= 1'b1;
        end else begin
            rsp_valid <= 2'b00;
            if (go_setup) begin
                state     <= SETUP;
                half      <= setup_half;
                cnt       <= '0;
                dq_oe     <= src.we;
                sram_addr <= SRAM_AW'({src.addr, setup_half});
                sram_ce_n <= 1'b0;
                sram_oe_n <= 1'b1;
                sram_we_n <= 1'b1;
                {sram_ub_n, sram_lb_n} <= half_lanes(src.we, src.be, setup_half);
            end
            case (state)
                IDLE: begin
                    if (take) begin
                        req_ready <= 2'b00;
                        port      <= accept;
                        if (!go_setup) begin
                            state     <= RESP;
                            rsp_valid <= accept;
                            rsp_rdata <= 32'h0;
                        end
                    end else begin
                        req_ready <= grant;
                    end
                end
                SETUP: begin
                    state     <= STROBE;
                    sram_oe_n <= cur.we;
                    sram_we_n <= !cur.we;
                end
                STROBE: begin
                    if (last_strobe) begin
                        state     <= HOLD;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!go_setup) begin
                        state     <= RESP;
                        dq_oe     <= 1'b0;
                        sram_ce_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        rsp_valid <= port;
                        rsp_rdata <= cur.we ? 32'h0 : {rbuf_hi, rbuf_lo};
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= grant;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Bench for sram_arbiter_ctrl: drivers push expected responses into a
// scoreboard queue; a monitor with an SRAM model pops and checks each response.
module tb_sram_arbiter_ctrl;
    localparam int AW = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          tb_valid [2];
    logic          tb_we    [2];
    logic [AW-2:0] tb_addr  [2];
    logic [31:0]   tb_wdata [2];
    logic [3:0]    tb_be    [2];

    logic [1:0]          req_valid, req_ready, req_we, rsp_valid;
    logic [1:0][AW-2:0]  req_addr;
    logic [1:0][31:0]    req_wdata;
    logic [1:0][3:0]     req_be;
    logic [31:0]         rsp_rdata;
    wire  [15:0]         sram_dq;
    logic [AW-1:0]       sram_addr;
    logic sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    assign req_valid = {tb_valid[1], tb_valid[0]};
    assign req_we    = {tb_we[1], tb_we[0]};
    assign req_addr  = {tb_addr[1], tb_addr[0]};
    assign req_wdata = {tb_wdata[1], tb_wdata[0]};
    assign req_be    = {tb_be[1], tb_be[0]};

    sram_arbiter_ctrl #(.SRAM_AW(AW), .WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_dq(sram_dq), .sram_addr(sram_addr),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
    );

    // Asynchronous SRAM model, byte lanes written while we_n is low.
    logic [15:0] mem [0:1023];
    assign sram_dq = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 16'bz;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) mem[sram_addr[9:0]][7:0]  <= sram_dq[7:0];
            if (!sram_ub_n) mem[sram_addr[9:0]][15:8] <= sram_dq[15:8];
        end
    end

    typedef struct { int port; logic [31:0] rdata; int due; } exp_t;
    typedef struct packed { logic ub_n; logic lb_n; logic half; } wstr_t;

    exp_t          q[$];
    int            acc_port[$];
    int            acc_cyc[$];
    logic [AW-1:0] addr_log[$];
    wstr_t         we_log[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic          prev_ce_n = 1'b1;
        logic [AW-1:0] prev_addr = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ce_n = 1'b1;
                continue;
            end
            if (!sram_ce_n) begin
                check("strobe_overlap", 32'(!sram_oe_n && !sram_we_n), 32'd0);
                if (prev_ce_n || sram_addr != prev_addr)
                    addr_log.push_back(sram_addr);
            end
            if (!sram_we_n)
                we_log.push_back({sram_ub_n, sram_lb_n, sram_addr[0]});
            prev_ce_n = sram_ce_n;
            prev_addr = sram_addr;
            if (rsp_valid != 2'b00) begin
                if (q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("rsp_owner", 32'(rsp_valid), 32'(2'b01 << e.port));
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    endtask

    task automatic issue(input int p, input logic we, input logic [AW-2:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rdata, input int lat, input bit push);
        int   n = 0;
        exp_t e;
        tb_we[p] = we; tb_addr[p] = addr; tb_wdata[p] = wdata; tb_be[p] = be;
        tb_valid[p] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[p] && n < 40);
        if (!req_ready[p]) begin
            check($sformatf("accept_timeout_p%0d", p), 32'd0, 32'd1);
            tb_valid[p] = 1'b0;
            return;
        end
        acc_port.push_back(p);
        acc_cyc.push_back(cyc);
        if (push) begin
            e.port = p; e.rdata = exp_rdata; e.due = cyc + lat;
            q.push_back(e);
        end
        @(posedge clk);
        #1 tb_valid[p] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        addr_log.delete();
        we_log.delete();
        acc_port.delete();
        acc_cyc.delete();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            tb_valid[i] = 1'b0; tb_we[i] = 1'b0; tb_addr[i] = '0;
            tb_wdata[i] = 32'h0; tb_be[i] = 4'h0;
        end
        fork monitor(); join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'h1F);
        check("rst_addr", 32'(sram_addr), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_dq_drive", 32'(dut.dq_oe), 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Full write then read back.
        clear_logs();
        issue(0, 1'b1, 19'h10, 32'hDEADBEEF, 4'hF, 32'h0, 7, 1'b1);
        drain();
        check("wr_addr_count", 32'(addr_log.size()), 32'd2);
        if (addr_log.size() == 2) begin
            check("wr_addr_lo", 32'(addr_log[0]), 32'h20);
            check("wr_addr_hi", 32'(addr_log[1]), 32'h21);
        end
        check("wr_strobe_count", 32'(we_log.size()), 32'd2);
        check("mem_lo", 32'(mem[10'h20]), 32'hBEEF);
        check("mem_hi", 32'(mem[10'h21]), 32'hDEAD);
        issue(0, 1'b0, 19'h10, 32'h0, 4'hF, 32'hDEADBEEF, 7, 1'b1);
        drain();

        // Lo-half-only write over a preset word.
        issue(0, 1'b1, 19'h20, 32'hAAAAAAAA, 4'hF, 32'h0, 7, 1'b1);
        drain();
        clear_logs();
        issue(0, 1'b1, 19'h20, 32'h12345678, 4'b0011, 32'h0, 4, 1'b1);
        drain();
        check("lo_strobe_count", 32'(we_log.size()), 32'd1);
        if (we_log.size() == 1) check("lo_strobe_half", 32'(we_log[0].half), 32'd0);
        check("lo_addr_count", 32'(addr_log.size()), 32'd1);
        if (addr_log.size() == 1) check("lo_addr", 32'(addr_log[0]), 32'h40);
        issue(0, 1'b0, 19'h20, 32'h0, 4'hF, 32'hAAAA5678, 7, 1'b1);
        drain();

        // be = 0000: no SRAM cycle at all.
        clear_logs();
        issue(0, 1'b1, 19'h50, 32'hFFFFFFFF, 4'b0000, 32'h0, 1, 1'b1);
        drain();
        check("be0_ce_activity", 32'(addr_log.size()), 32'd0);
        check("be0_we_activity", 32'(we_log.size()), 32'd0);

        // Single byte in the hi half; readback on port 1.
        issue(0, 1'b1, 19'h30, 32'hAAAAAAAA, 4'hF, 32'h0, 7, 1'b1);
        drain();
        clear_logs();
        issue(0, 1'b1, 19'h30, 32'h12345678, 4'b0100, 32'h0, 4, 1'b1);
        drain();
        check("hi_strobe_count", 32'(we_log.size()), 32'd1);
        if (we_log.size() == 1) check("hi_lanes_half", 32'(we_log[0]), 32'b101);
        issue(1, 1'b0, 19'h30, 32'h0, 4'hF, 32'hAA34AAAA, 7, 1'b1);
        drain();

        // Both ports reading continuously.
        clear_logs();
        fork
            begin
                issue(0, 1'b0, 19'h10, 32'h0, 4'hF, 32'hDEADBEEF, 7, 1'b1);
                issue(0, 1'b0, 19'h10, 32'h0, 4'hF, 32'hDEADBEEF, 7, 1'b1);
            end
            begin
                issue(1, 1'b0, 19'h20, 32'h0, 4'hF, 32'hAAAA5678, 7, 1'b1);
                issue(1, 1'b0, 19'h20, 32'h0, 4'hF, 32'hAAAA5678, 7, 1'b1);
            end
        join
        drain();
        check("rr_accept_count", 32'(acc_port.size()), 32'd4);
        if (acc_port.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("rr_grant_%0d", i), 32'(acc_port[i]), 32'(i % 2));
            for (int i = 1; i < 4; i++)
                check($sformatf("rr_spacing_%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd8);
        end

        // Reset during the lo STROBE of a write.
        clear_logs();
        issue(0, 1'b1, 19'h40, 32'h00000055, 4'b0001, 32'h0, 4, 1'b0);
        n = 0;
        while (sram_we_n && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("reach_strobe", 32'(sram_we_n), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_we_n", 32'(sram_we_n), 32'd1);
        check("midrst_ce_n", 32'(sram_ce_n), 32'd1);
        check("midrst_dq_drive", 32'(dut.dq_oe), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clear_logs();
        fork
            issue(0, 1'b0, 19'h10, 32'h0, 4'hF, 32'hDEADBEEF, 7, 1'b1);
            issue(1, 1'b0, 19'h20, 32'h0, 4'hF, 32'hAAAA5678, 7, 1'b1);
        join
        drain();
        check("postrst_count", 32'(acc_port.size()), 32'd2);
        if (acc_port.size() == 2) check("postrst_first_port", 32'(acc_port[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
